// File: rtl/vga_fb_arbiter.sv
// Purpose: shares one framebuffer RAM port between display fetch, a single-word writer and a frame-clear engine.
// Latency: fetch issued 2 pixels ahead of the beam; writer sees ram_we in the request cycle, wr_ack one cycle later.
// Backpressure: display fetch always wins; writer and clear stall on fetch slots, writer is not served while clearing.
module vga_fb_arbiter #(
    parameter int SCREEN_X = 1368,
    parameter int SCREEN_Y = 768,
    parameter int H_PERIOD = 1801,
    parameter int V_PERIOD = 796,
    parameter int FB_W     = 171,
    parameter int FB_H     = 96
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] posX,
    input  logic [10:0] posY,
    output logic [2:0]  pixel,
    output logic [14:0] ram_addr,
    output logic        ram_we,
    output logic [2:0]  ram_wdata,
    input  logic [2:0]  ram_rdata,
    input  logic        wr_req,
    input  logic [14:0] wr_addr,
    input  logic [2:0]  wr_data,
    output logic        wr_ack,
    output logic        wr_err,
    input  logic        clr_req,
    input  logic [2:0]  clr_color,
    output logic        clr_busy,
    output logic        frame_start
);

    localparam int FB_SIZE = FB_W * FB_H;

    typedef enum logic [1:0] {IDLE, ACK, CLEAR} state_t;

    state_t      state;
    logic [14:0] clrCnt;
    logic [2:0]  clrColorQ;
    logic        fetchQ;
    logic [2:0]  pixReg;

    logic [11:0] txSum;
    logic [11:0] tySum;
    logic [10:0] tx;
    logic [10:0] ty;
    logic        fetch;
    logic [14:0] fetchAddr;
    logic        wrInRange;

    // Look two pixels ahead so RAM read data lands in the pixel register just as the beam enters the cell.
    always_comb begin
        txSum = {1'b0, posX} + 12'd2;
        tySum = {1'b0, posY};
        if (txSum >= 12'(H_PERIOD)) begin
            txSum = txSum - 12'(H_PERIOD);
            tySum = tySum + 12'd1;
        end
        if (tySum >= 12'(V_PERIOD)) begin
            tySum = 12'd0;
        end
        tx = txSum[10:0];
        ty = tySum[10:0];
    end

    assign fetch     = (tx < 11'(SCREEN_X)) && (ty < 11'(SCREEN_Y)) && (tx[2:0] == 3'd0);
    assign fetchAddr = 15'(ty[10:3]) * 15'(FB_W) + 15'(tx[10:3]);
    assign wrInRange = (wr_addr < 15'(FB_SIZE));

    // RAM port mux: fetch owns the port in its slot, otherwise the writer (IDLE) or the clear engine drives it.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = 15'd0;
        ram_wdata = 3'd0;
        if (fetch) begin
            ram_addr = fetchAddr;
        end else if (!rst) begin
            case (state)
                IDLE: begin
                    if (!clr_req && wr_req && wrInRange) begin
                        ram_we    = 1'b1;
                        ram_addr  = wr_addr;
                        ram_wdata = wr_data;
                    end
                end
                CLEAR: begin
                    ram_we    = 1'b1;
                    ram_addr  = clrCnt;
                    ram_wdata = clrColorQ;
                end
                default: begin
                    ram_we = 1'b0;
                end
            endcase
        end
    end

    // Writer / clear sequencer with registered ack, error and busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clrCnt    <= 15'd0;
            clrColorQ <= 3'd0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
            clr_busy  <= 1'b0;
        end else begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state     <= CLEAR;
                        clrCnt    <= 15'd0;
                        clrColorQ <= clr_color;
                        clr_busy  <= 1'b1;
                    end else if (wr_req && !fetch) begin
                        state  <= ACK;
                        wr_ack <= 1'b1;
                        wr_err <= !wrInRange;
                    end
                end
                ACK: begin
                    // A clear requested while acking is taken straight after the ack cycle.
                    if (clr_req) begin
                        state     <= CLEAR;
                        clrCnt    <= 15'd0;
                        clrColorQ <= clr_color;
                        clr_busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    if (!fetch) begin
                        if (clrCnt == 15'(FB_SIZE - 1)) begin
                            state    <= IDLE;
                            clrCnt   <= 15'd0;
                            clr_busy <= 1'b0;
                        end else begin
                            clrCnt <= clrCnt + 15'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture read data one cycle after the fetch address was presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchQ <= 1'b0;
            pixReg <= 3'd0;
        end else begin
            fetchQ <= fetch;
            if (fetchQ) begin
                pixReg <= ram_rdata;
            end
        end
    end

    assign pixel       = ((posX < 11'(SCREEN_X)) && (posY < 11'(SCREEN_Y))) ? pixReg : 3'd0;
    assign frame_start = (posX == 11'd0) && (posY == 11'd0);

endmodule
